// File: rtl/idex_fwd_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble insertion.
// Drives ALU operands, opcode and forwarded store data directly into the EX stage.
module idex_fwd_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_id_valid,
  input  logic [XLEN-1:0]    i_id_pc,
  input  logic [RADDR_W-1:0] i_id_rs1_addr,
  input  logic [RADDR_W-1:0] i_id_rs2_addr,
  input  logic [XLEN-1:0]    i_id_rs1_data,
  input  logic [XLEN-1:0]    i_id_rs2_data,
  input  logic [XLEN-1:0]    i_id_imm,
  input  logic [RADDR_W-1:0] i_id_rd_addr,
  input  logic               i_id_rd_wren,
  input  logic               i_id_is_load,
  input  logic [3:0]         i_id_alu_op,
  input  logic               i_id_opa_sel,
  input  logic               i_id_opb_sel,
  input  logic [RADDR_W-1:0] i_mem_rd_addr,
  input  logic               i_mem_rd_wren,
  input  logic [XLEN-1:0]    i_mem_data,
  input  logic [RADDR_W-1:0] i_wb_rd_addr,
  input  logic               i_wb_rd_wren,
  input  logic [XLEN-1:0]    i_wb_data,
  output logic [XLEN-1:0]    o_op_a,
  output logic [XLEN-1:0]    o_op_b,
  output logic [3:0]         o_alu_op,
  output logic [XLEN-1:0]    o_store_data,
  output logic [XLEN-1:0]    o_pc,
  output logic [RADDR_W-1:0] o_rd_addr,
  output logic               o_rd_wren,
  output logic               o_is_load,
  output logic               o_valid,
  output logic               o_load_use
);

  logic               vld_p1;
  logic               rd_wren_p1;
  logic               is_load_p1;
  logic [3:0]         alu_op_p1;
  logic [XLEN-1:0]    pc_p1;
  logic [RADDR_W-1:0] rd_addr_p1;
  logic [RADDR_W-1:0] rs1_addr_p1;
  logic [RADDR_W-1:0] rs2_addr_p1;
  logic [XLEN-1:0]    rs1_data_p1;
  logic [XLEN-1:0]    rs2_data_p1;
  logic [XLEN-1:0]    imm_p1;
  logic               opa_sel_p1;
  logic               opb_sel_p1;

  logic               bubble;
  logic               capture;
  logic [XLEN-1:0]    rs1_fwd;
  logic [XLEN-1:0]    rs2_fwd;

  // Regfile write and read land in the same cycle, so take the WB value at capture.
  function automatic logic [XLEN-1:0] wb_bypass(
    input logic [RADDR_W-1:0] rs,
    input logic [XLEN-1:0]    rf_data,
    input logic               wb_we,
    input logic [RADDR_W-1:0] wb_rd,
    input logic [XLEN-1:0]    wb_d
  );
    if (wb_we && (wb_rd != '0) && (wb_rd == rs)) return wb_d;
    return rf_data;
  endfunction

  // Youngest producer (MEM) wins over WB; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [RADDR_W-1:0] rs,
    input logic [XLEN-1:0]    reg_data,
    input logic               mem_we,
    input logic [RADDR_W-1:0] mem_rd,
    input logic [XLEN-1:0]    mem_d,
    input logic               wb_we,
    input logic [RADDR_W-1:0] wb_rd,
    input logic [XLEN-1:0]    wb_d
  );
    if (mem_we && (mem_rd != '0) && (mem_rd == rs)) return mem_d;
    if (wb_we && (wb_rd != '0) && (wb_rd == rs)) return wb_d;
    return reg_data;
  endfunction

  assign o_load_use = !i_flush && vld_p1 && is_load_p1 && rd_wren_p1 &&
                      (rd_addr_p1 != '0) && i_id_valid &&
                      ((rd_addr_p1 == i_id_rs1_addr) || (rd_addr_p1 == i_id_rs2_addr));

  assign bubble  = i_flush || (!i_stall && o_load_use);
  assign capture = !i_flush && !i_stall && !o_load_use;

  // ID -> EX boundary
  always_ff @(posedge i_clk) begin
    if (i_reset || bubble) begin
      vld_p1      <= 1'b0;
      rd_wren_p1  <= 1'b0;
      is_load_p1  <= 1'b0;
      alu_op_p1   <= '0;
      pc_p1       <= '0;
      rd_addr_p1  <= '0;
      rs1_addr_p1 <= '0;
      rs2_addr_p1 <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      opa_sel_p1  <= 1'b0;
      opb_sel_p1  <= 1'b0;
    end else if (capture) begin
      vld_p1      <= i_id_valid;
      rd_wren_p1  <= i_id_rd_wren;
      is_load_p1  <= i_id_is_load;
      alu_op_p1   <= i_id_alu_op;
      pc_p1       <= i_id_pc;
      rd_addr_p1  <= i_id_rd_addr;
      rs1_addr_p1 <= i_id_rs1_addr;
      rs2_addr_p1 <= i_id_rs2_addr;
      rs1_data_p1 <= wb_bypass(i_id_rs1_addr, i_id_rs1_data, i_wb_rd_wren, i_wb_rd_addr, i_wb_data);
      rs2_data_p1 <= wb_bypass(i_id_rs2_addr, i_id_rs2_data, i_wb_rd_wren, i_wb_rd_addr, i_wb_data);
      imm_p1      <= i_id_imm;
      opa_sel_p1  <= i_id_opa_sel;
      opb_sel_p1  <= i_id_opb_sel;
    end
  end

  assign rs1_fwd = fwd_mux(rs1_addr_p1, rs1_data_p1, i_mem_rd_wren, i_mem_rd_addr, i_mem_data,
                           i_wb_rd_wren, i_wb_rd_addr, i_wb_data);
  assign rs2_fwd = fwd_mux(rs2_addr_p1, rs2_data_p1, i_mem_rd_wren, i_mem_rd_addr, i_mem_data,
                           i_wb_rd_wren, i_wb_rd_addr, i_wb_data);

  assign o_op_a       = opa_sel_p1 ? pc_p1 : rs1_fwd;
  assign o_op_b       = opb_sel_p1 ? imm_p1 : rs2_fwd;
  assign o_store_data = rs2_fwd;
  assign o_alu_op     = alu_op_p1;
  assign o_pc         = pc_p1;
  assign o_rd_addr    = rd_addr_p1;
  assign o_rd_wren    = rd_wren_p1;
  assign o_is_load    = is_load_p1;
  assign o_valid      = vld_p1;

endmodule

// File: tb/tb_idex_fwd_stage.sv
// Bench for idex_fwd_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_idex_fwd_stage;
  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, stall, flush;
  logic               id_valid, id_rd_wren, id_is_load, id_opa_sel, id_opb_sel;
  logic [XLEN-1:0]    id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RADDR_W-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]         id_alu_op;
  logic [RADDR_W-1:0] mem_rd_addr, wb_rd_addr;
  logic               mem_rd_wren, wb_rd_wren;
  logic [XLEN-1:0]    mem_data, wb_data;
  logic [XLEN-1:0]    op_a, op_b, store_data, pc;
  logic [3:0]         alu_op;
  logic [RADDR_W-1:0] rd_addr;
  logic               rd_wren, is_load, valid, load_use;

  idex_fwd_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_pc(id_pc),
    .i_id_rs1_addr(id_rs1_addr), .i_id_rs2_addr(id_rs2_addr),
    .i_id_rs1_data(id_rs1_data), .i_id_rs2_data(id_rs2_data),
    .i_id_imm(id_imm), .i_id_rd_addr(id_rd_addr), .i_id_rd_wren(id_rd_wren),
    .i_id_is_load(id_is_load), .i_id_alu_op(id_alu_op),
    .i_id_opa_sel(id_opa_sel), .i_id_opb_sel(id_opb_sel),
    .i_mem_rd_addr(mem_rd_addr), .i_mem_rd_wren(mem_rd_wren), .i_mem_data(mem_data),
    .i_wb_rd_addr(wb_rd_addr), .i_wb_rd_wren(wb_rd_wren), .i_wb_data(wb_data),
    .o_op_a(op_a), .o_op_b(op_b), .o_alu_op(alu_op), .o_store_data(store_data),
    .o_pc(pc), .o_rd_addr(rd_addr), .o_rd_wren(rd_wren), .o_is_load(is_load),
    .o_valid(valid), .o_load_use(load_use)
  );

  // Model of the instruction sitting in EX.
  typedef struct packed {
    logic        v, we, ld, asel, bsel;
    logic [3:0]  op;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rd, rs1, rs2;
  } ex_t;

  ex_t m;
  bit  armed = 1'b0;
  int  total = 0;
  int  bad   = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] d);
    if (mem_rd_wren && mem_rd_addr != 0 && mem_rd_addr == rs) return mem_data;
    if (wb_rd_wren && wb_rd_addr != 0 && wb_rd_addr == rs) return wb_data;
    return d;
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] rs, input logic [31:0] d);
    if (wb_rd_wren && wb_rd_addr != 0 && wb_rd_addr == rs) return wb_data;
    return d;
  endfunction

  function automatic logic exp_lu();
    return !flush && m.v && m.ld && m.we && (m.rd != 0) && id_valid &&
           (m.rd == id_rs1_addr || m.rd == id_rs2_addr);
  endfunction

  task automatic check_model();
    logic [31:0] f2;
    if (!armed) return;
    f2 = fwd(m.rs2, m.d2);
    cmp("op_a",       op_a,       m.asel ? m.pc : fwd(m.rs1, m.d1));
    cmp("op_b",       op_b,       m.bsel ? m.imm : f2);
    cmp("store_data", store_data, f2);
    cmp("alu_op",     {28'd0, alu_op},  {28'd0, m.op});
    cmp("pc",         pc,         m.pc);
    cmp("rd_addr",    {27'd0, rd_addr}, {27'd0, m.rd});
    cmp("rd_wren",    {31'd0, rd_wren}, {31'd0, m.we});
    cmp("is_load",    {31'd0, is_load}, {31'd0, m.ld});
    cmp("valid",      {31'd0, valid},   {31'd0, m.v});
    cmp("load_use",   {31'd0, load_use}, {31'd0, exp_lu()});
  endtask

  task automatic update_model();
    ex_t n;
    n = m;
    if (reset || flush) n = '0;
    else if (stall) n = m;
    else if (exp_lu()) n = '0;
    else begin
      n.v = id_valid; n.we = id_rd_wren; n.ld = id_is_load;
      n.asel = id_opa_sel; n.bsel = id_opb_sel; n.op = id_alu_op;
      n.pc = id_pc; n.imm = id_imm; n.rd = id_rd_addr;
      n.rs1 = id_rs1_addr; n.rs2 = id_rs2_addr;
      n.d1 = rf_read(id_rs1_addr, id_rs1_data);
      n.d2 = rf_read(id_rs2_addr, id_rs2_data);
    end
    m = n;
    if (reset) armed = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; flush = 0;
    id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_rd_addr = 0;
    id_rd_wren = 0; id_is_load = 0; id_alu_op = 0; id_opa_sel = 0; id_opb_sel = 0;
    mem_rd_addr = 0; mem_rd_wren = 0; mem_data = 0;
    wb_rd_addr = 0; wb_rd_wren = 0; wb_data = 0;
  endtask

  task automatic set_id(input logic [31:0] p, input logic [4:0] r1, input logic [31:0] d1,
                        input logic [4:0] r2, input logic [31:0] d2, input logic [31:0] im,
                        input logic [4:0] rd, input logic ld, input logic [3:0] op,
                        input logic as, input logic bs);
    id_valid = 1; id_pc = p; id_rs1_addr = r1; id_rs1_data = d1;
    id_rs2_addr = r2; id_rs2_data = d2; id_imm = im; id_rd_addr = rd;
    id_rd_wren = 1; id_is_load = ld; id_alu_op = op; id_opa_sel = as; id_opb_sel = bs;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    advance();
    advance();
    reset = 0;

    // Reset mid-stream
    set_id(32'h40, 5'd1, 32'h1234, 5'd2, 32'h0, 32'h0, 5'd3, 0, 4'b0000, 0, 0);
    settle();
    cmp("reset_idle_valid", {31'd0, valid}, 32'd0);
    advance();
    settle();
    cmp("add_loaded_valid", {31'd0, valid}, 32'd1);
    cmp("add_loaded_op_a", op_a, 32'h1234);
    reset = 1;
    advance();
    reset = 0;
    idle_inputs();
    settle();
    cmp("rst_valid", {31'd0, valid}, 32'd0);
    cmp("rst_rd_wren", {31'd0, rd_wren}, 32'd0);
    cmp("rst_op_a", op_a, 32'h0);
    cmp("rst_load_use", {31'd0, load_use}, 32'd0);

    // MEM over WB priority, x0 never forwarded
    set_id(32'h44, 5'd5, 32'h11, 5'd6, 32'h0, 32'h0, 5'd9, 0, 4'b0000, 0, 0);
    advance();
    idle_inputs();
    stall = 1;
    mem_rd_wren = 1; mem_rd_addr = 5; mem_data = 32'h22;
    wb_rd_wren = 1;  wb_rd_addr = 5;  wb_data = 32'h33;
    settle();
    cmp("fwd_mem_prio", op_a, 32'h22);
    advance();
    mem_rd_wren = 0;
    settle();
    cmp("fwd_wb", op_a, 32'h33);
    advance();
    mem_rd_wren = 1; mem_rd_addr = 0; mem_data = 32'h44;
    settle();
    cmp("fwd_x0_ignored", op_a, 32'h33);
    advance();
    idle_inputs();

    // Load-use bubble then capture bypass
    set_id(32'h48, 5'd1, 32'h0, 5'd0, 32'h0, 32'h0, 5'd7, 1, 4'b0000, 0, 0);
    advance();
    set_id(32'h4C, 5'd7, 32'h0, 5'd2, 32'h2, 32'h0, 5'd8, 0, 4'b0000, 0, 0);
    settle();
    cmp("load_use_hit", {31'd0, load_use}, 32'd1);
    advance();
    settle();
    cmp("bubble_valid", {31'd0, valid}, 32'd0);
    cmp("bubble_rd_wren", {31'd0, rd_wren}, 32'd0);
    wb_rd_wren = 1; wb_rd_addr = 7; wb_data = 32'hDEAD;
    advance();
    wb_rd_wren = 0;
    settle();
    cmp("lu_bypass_op_a", op_a, 32'hDEAD);
    cmp("lu_resume_valid", {31'd0, valid}, 32'd1);
    advance();
    idle_inputs();

    // Flush beats stall; stall holds everything
    set_id(32'h50, 5'd1, 32'h0, 5'd2, 32'h0, 32'h0, 5'd4, 0, 4'b0001, 0, 0);
    advance();
    flush = 1; stall = 1;
    settle();
    cmp("flush_no_lu", {31'd0, load_use}, 32'd0);
    advance();
    idle_inputs();
    settle();
    cmp("flush_stall_valid", {31'd0, valid}, 32'd0);
    set_id(32'h200, 5'd1, 32'h0, 5'd2, 32'h0, 32'h77, 5'd4, 0, 4'b0011, 0, 1);
    advance();
    for (int k = 0; k < 3; k++) begin
      stall = 1;
      set_id($urandom, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
             $urandom, 5'($urandom_range(0, 7)), 0, 4'($urandom), 0, 0);
      settle();
      cmp("stall_pc", pc, 32'h200);
      cmp("stall_op_b", op_b, 32'h77);
      cmp("stall_alu_op", {28'd0, alu_op}, 32'd3);
      advance();
    end
    idle_inputs();

    // Operand select: PC and immediate
    set_id(32'h100, 5'd1, 32'h0, 5'd4, 32'h99, 32'hFFFF_FFFC, 5'd6, 0, 4'b0000, 1, 1);
    advance();
    idle_inputs();
    mem_rd_wren = 1; mem_rd_addr = 4; mem_data = 32'hABC;
    settle();
    cmp("sel_op_a_pc", op_a, 32'h100);
    cmp("sel_op_b_imm", op_b, 32'hFFFF_FFFC);
    cmp("sel_store_fwd", store_data, 32'hABC);
    advance();
    idle_inputs();

    // Capture bypass into store data
    set_id(32'h104, 5'd0, 32'h0, 5'd3, 32'h0, 32'h0, 5'd0, 0, 4'b0000, 0, 0);
    wb_rd_wren = 1; wb_rd_addr = 3; wb_data = 32'h5A;
    advance();
    idle_inputs();
    settle();
    cmp("cap_bypass_store", store_data, 32'h5A);
    advance();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      stall       = ($urandom_range(0, 6) == 0);
      id_valid    = ($urandom_range(0, 7) != 0);
      id_pc       = $urandom;
      id_rs1_addr = 5'($urandom_range(0, 7));
      id_rs2_addr = 5'($urandom_range(0, 7));
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      id_imm      = $urandom;
      id_rd_addr  = 5'($urandom_range(0, 7));
      id_rd_wren  = ($urandom_range(0, 3) != 0);
      id_is_load  = ($urandom_range(0, 2) == 0);
      id_alu_op   = 4'($urandom_range(0, 11));
      id_opa_sel  = 1'($urandom);
      id_opb_sel  = 1'($urandom);
      mem_rd_addr = 5'($urandom_range(0, 7));
      mem_rd_wren = 1'($urandom);
      mem_data    = $urandom;
      wb_rd_addr  = 5'($urandom_range(0, 7));
      wb_rd_wren  = 1'($urandom);
      wb_data     = $urandom;
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/idex_fwd_stage.md
Name: idex_fwd_stage

Overview:
ID/EX pipeline register plus operand-forwarding and load-use hazard logic for the forwarding pipeline. It captures decoded fields from ID and resolves RAW hazards against the EX/MEM and MEM/WB stages. It drives the ALU operand, opcode and store-data inputs, and inserts one bubble on a load-use hazard. It sits directly upstream of the ALU in the EX stage.

Parameters:
XLEN, 32, datapath width
RADDR_W, 5, register address width

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_stall  in  1  freeze EX register (pipeline-wide stall)
i_flush  in  1  squash EX contents (branch redirect)
i_id_valid  in  1  ID holds a real instruction
i_id_pc  in  XLEN  ID PC
i_id_rs1_addr / i_id_rs2_addr  in  RADDR_W  source register indices
i_id_rs1_data / i_id_rs2_data  in  XLEN  regfile read data (no internal bypass)
i_id_imm  in  XLEN  immediate
i_id_rd_addr  in  RADDR_W  destination register
i_id_rd_wren  in  1  instruction writes rd
i_id_is_load  in  1  instruction is a load
i_id_alu_op  in  4  ALU opcode (0000 ADD … 1011 pass-B)
i_id_opa_sel  in  1  0: rs1, 1: PC
i_id_opb_sel  in  1  0: rs2, 1: imm
i_mem_rd_addr, i_mem_rd_wren, i_mem_data  in  RADDR_W/1/XLEN  EX/MEM destination and ALU result
i_wb_rd_addr, i_wb_rd_wren, i_wb_data  in  RADDR_W/1/XLEN  MEM/WB destination and final writeback data
o_op_a, o_op_b  out  XLEN  ALU operands
o_alu_op  out  4  ALU opcode
o_store_data  out  XLEN  forwarded rs2 for stores
o_pc, o_rd_addr, o_rd_wren, o_is_load, o_valid  out  –  registered EX fields
o_load_use  out  1  combinational; upstream must hold PC and IF/ID this cycle

Behaviour:
- Reset (sync, highest priority): all EX registers cleared.
  - Resulting outputs: o_valid=0, o_rd_wren=0, o_is_load=0, o_alu_op=0000, o_pc=0, o_rd_addr=0, o_op_a=0, o_op_b=0, o_store_data=0, o_load_use=0.
- EX register update priority per clock edge: reset > i_flush > i_stall > load-use bubble > normal load.
  - Flush: write bubble (valid=0, rd_wren=0, is_load=0, alu_op=0000, data fields 0).
  - Stall: all fields hold.
  - Bubble: same as flush.
  - Normal: capture all ID fields.
- Capture bypass: on normal load, if i_wb_rd_wren and i_wb_rd_addr!=0 and i_wb_rd_addr==i_id_rsN_addr, register i_wb_data instead of i_id_rsN_data. This covers regfile write/read in the same cycle.
- Load-use detect (combinational): o_load_use=1 iff all of the following hold:
  - EX valid, is_load and rd_wren are set, and EX rd!=0.
  - i_id_valid is set.
  - EX rd equals i_id_rs1_addr or i_id_rs2_addr.
  - Raised regardless of opa/opb selects (conservative).
  - Forced to 0 when i_flush=1.
  - Under i_stall=1, o_load_use may assert, but the register holds (stall wins).
- Forwarding (combinational from registered rs addr/data):
  - Operand rsN_fwd = i_mem_data if i_mem_rd_wren, i_mem_rd_addr!=0, and i_mem_rd_addr==rsN.
  - Else i_wb_data if the same conditions hold on the WB port.
  - Else registered data.
  - MEM takes priority over WB. Register 0 is never forwarded.
- Operand select:
  - o_op_a = opa_sel ? o_pc : rs1_fwd.
  - o_op_b = opb_sel ? imm : rs2_fwd.
  - o_store_data = rs2_fwd always.
- Bubble outputs:
  - Forwarding muxes still evaluate, but o_rd_wren=0, so downstream ignores the result.
  - o_alu_op=0000.
- Latency: one cycle ID→EX register. Forwarding and operand selection add zero cycles.
- Stall while WB data retires: no operand re-capture. The whole pipe freezes under i_stall, so MEM/WB inputs also hold.

Test Plan:
1. Reset mid-stream: load ADD (rs1=x1), assert i_reset one cycle → next cycle o_valid=0, o_rd_wren=0, o_op_a=0, o_load_use=0.
2. MEM forward priority: EX rs1=x5 holds 0x11, MEM writes x5=0x22, WB writes x5=0x33 → o_op_a=0x22; drop MEM match → 0x33; set MEM rd=x0 with data 0x44 → 0x33.
3. Load-use: EX holds `lw x7`, ID `add x8,x7,x2` → o_load_use=1. Next edge gives EX o_valid=0, o_rd_wren=0. With ID held and WB writing x7=0xDEAD at the following edge → capture bypass gives o_op_a=0xDEAD.
4. Flush vs stall: i_flush=1 and i_stall=1 together → EX becomes bubble (o_valid=0). i_stall alone for 3 cycles → o_pc, o_op_b, o_alu_op unchanged.
5. Operand select: opa_sel=1, pc=0x100, opb_sel=1, imm=0xFFFFFFFC, alu_op=0000 → o_op_a=0x100, o_op_b=0xFFFFFFFC, o_store_data=forwarded rs2.
6. Capture bypass: ID rs2=x3 with regfile 0x0, WB writes x3=0x5A same cycle → after edge o_store_data=0x5A with no active forward.
